// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_RUN,
    FS_SQUASH,
    FS_FAULT
  } fetch_state_t;

  // Redirect targets are word addresses; the two low bits carry no meaning.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_timeout.sv
// Wait-cycle watchdog for the fetch port; only elaborated when FETCH_TIMEOUT_EN is defined.
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_counter #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic limit_hit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (count_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fires during the LIMIT-th consecutive busy cycle so the fault lands on the next edge.
  assign limit_hit = count_en & ~clear & (r_cnt == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, drives a req/ack instruction port and fills one decode slot.
// Optional watchdog fault on a stuck memory port is enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned     TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_d,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  output logic            fetch_busy,
  output logic            fetch_fault
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pending;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_in_flight;
  logic            r_valid;
  logic [XLEN-1:0] w_target;
  logic            w_slot_free;
  logic            w_req;
  logic            w_ack;
  logic            w_busy;
  logic            w_limit_hit;
  logic            w_fault;

  assign w_target    = word_align(redirect_pc);
  assign w_slot_free = ~r_valid | ~stall_d;
  assign w_ack       = w_req & imem_ack;
  assign w_busy      = w_req & ~imem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FS_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FS_RUN:    if (redirect && w_busy) w_state_nxt = FS_SQUASH;
      FS_SQUASH: if (w_ack) w_state_nxt = FS_RUN;
      default:   w_state_nxt = r_state;
    endcase
    if (w_limit_hit) w_state_nxt = FS_FAULT;
  end

  // A request already on the bus is held to its ack regardless of stalls or redirects.
  always_comb begin
    w_req = 1'b0;
    if (!rst && r_state != FS_FAULT) begin
      w_req = r_in_flight | ((r_state == FS_RUN) & w_slot_free);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_pending   <= '0;
      r_in_flight <= 1'b0;
      r_valid     <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_instr_pc  <= '0;
    end else begin
      r_in_flight <= w_busy;
      unique case (r_state)
        FS_RUN: begin
          if (redirect) begin
            r_valid <= 1'b0;
            if (w_busy) r_pending <= w_target;
            else        r_pc      <= w_target;
          end else if (w_ack) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= r_pc + 32'd4;
          end else if (r_valid && !stall_d) begin
            r_valid <= 1'b0;
          end
        end
        FS_SQUASH: begin
          // The squashed ack's data is dropped; the newest redirect target wins.
          r_valid <= 1'b0;
          if (w_ack)         r_pc      <= redirect ? w_target : r_pending;
          else if (redirect) r_pending <= w_target;
        end
        default: r_valid <= 1'b0;
      endcase
      if (w_limit_hit) r_valid <= 1'b0;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic r_fault;

  fetch_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .count_en  (w_busy),
    .clear     (w_ack | redirect),
    .limit_hit (w_limit_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault <= 1'b0;
    end else if (w_limit_hit) begin
      r_fault <= 1'b1;
    end
  end

  assign w_fault = r_fault;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_limit_hit = 1'b0;
  assign w_fault     = 1'b0;
`endif

  assign imem_req       = w_req;
  assign imem_addr      = r_pc;
  assign fetch_busy     = w_busy;
  assign instr_valid    = r_valid;
  assign instr          = r_valid ? r_instr : NOP_INSTR;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc + 32'd4;
  assign fetch_fault    = w_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by randomized traffic.
module tb_fetch_sequencer;

  localparam int          TO   = 8;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        fetch_busy;
  logic        fetch_fault;

  fetch_sequencer #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_d        (stall_d),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .fetch_busy     (fetch_busy),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory responder: latency in wait cycles per request, negative picks 0..3 at random.
  int lat_cfg;
  bit mem_active;
  int mem_cnt;
  int mem_wait;

  // Reference view: where fetch is, whether a request is outstanding, what the slot holds.
  logic [31:0] m_pc, m_target, m_instr, m_ipc;
  bit          m_waiting, m_squash, m_valid, m_fault;
  int          m_busy_run;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc       = 32'h0;
    m_target   = 32'h0;
    m_instr    = NOP;
    m_ipc      = 32'h0;
    m_waiting  = 1'b0;
    m_squash   = 1'b0;
    m_valid    = 1'b0;
    m_fault    = 1'b0;
    m_busy_run = 0;
    mem_active = 1'b0;
    mem_cnt    = 0;
  endtask

  // Asynchronous reset, checked immediately and then held for two edges.
  task automatic do_reset();
    rst         = 1'b1;
    stall_d     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    chk("rst_req",   32'(imem_req), 32'h0);
    chk("rst_busy",  32'(fetch_busy), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc",    instr_pc, 32'h0);
    chk("rst_pc4",   instr_pc_plus4, 32'h4);
    chk("rst_fault", 32'(fetch_fault), 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    rst = 1'b0;
  endtask

  // One clock: drive at edge+1, memory responds at edge+2, check at edge+3, advance model after edge.
  task automatic cyc(input bit s, input bit r, input logic [31:0] t);
    bit exp_req, a, busy, req_s;
    stall_d     = s;
    redirect    = r;
    redirect_pc = t;
    #1;
    if (imem_req) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_cnt    = 0;
        mem_wait   = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
      end
      imem_ack = (mem_cnt == mem_wait);
    end else begin
      imem_ack = 1'b0;
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    #1;
    exp_req = !m_fault && (m_waiting || (!m_squash && (!m_valid || !s)));
    chk("req",   32'(imem_req), 32'(exp_req));
    chk("addr",  imem_addr, m_pc);
    chk("busy",  32'(fetch_busy), 32'(exp_req && !imem_ack));
    chk("valid", 32'(instr_valid), 32'(m_valid));
    chk("instr", instr, m_valid ? m_instr : NOP);
    chk("ipc",   instr_pc, m_ipc);
    chk("ipc4",  instr_pc_plus4, m_ipc + 32'd4);
    chk("fault", 32'(fetch_fault), 32'(m_fault));
    a     = imem_ack;
    req_s = imem_req;
    busy  = exp_req && !a;
    @(posedge clk);
    #1;
    if (a) mem_active = 1'b0;
    else if (req_s) mem_cnt++;
    imem_ack = 1'b0;
    if (!m_fault) begin
      if (m_squash) begin
        if (a) begin
          m_pc     = r ? align(t) : m_target;
          m_squash = 1'b0;
        end else if (r) begin
          m_target = align(t);
        end
        m_valid = 1'b0;
      end else if (r) begin
        m_valid = 1'b0;
        if (busy) begin
          m_squash = 1'b1;
          m_target = align(t);
        end else begin
          m_pc = align(t);
        end
      end else if (a) begin
        m_valid = 1'b1;
        m_instr = mem_word(m_pc);
        m_ipc   = m_pc;
        m_pc    = m_pc + 32'd4;
      end else if (!s) begin
        m_valid = 1'b0;
      end
      m_waiting = busy;
`ifdef FETCH_TIMEOUT_EN
      m_busy_run = (busy && !r) ? m_busy_run + 1 : 0;
      if (m_busy_run == TO) begin
        m_fault   = 1'b1;
        m_valid   = 1'b0;
        m_waiting = 1'b0;
      end
`endif
    end
  endtask

  initial begin
    lat_cfg = 0;
    m_reset();
    do_reset();
    chk("boot_addr", imem_addr, 32'h0);

    // Zero-wait memory: one instruction per cycle.
    lat_cfg = 0;
    cyc(0, 0, 0);
    chk("zw_addr1", imem_addr, 32'h4);
    chk("zw_valid1", 32'(instr_valid), 32'h1);
    chk("zw_pc1", instr_pc, 32'h0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("zw_addr3", imem_addr, 32'hC);
    chk("zw_pc3", instr_pc, 32'h8);

    // Three-cycle memory.
    lat_cfg = 2;
    repeat (3) cyc(0, 0, 0);
    chk("lat3_valid", 32'(instr_valid), 32'h1);
    chk("lat3_pc", instr_pc, 32'hC);
    chk("lat3_addr", imem_addr, 32'h10);

    // Decode stall holds the slot and blocks new requests.
    lat_cfg = 0;
    repeat (4) cyc(1, 0, 0);
    chk("stall_pc", instr_pc, 32'hC);
    chk("stall_instr", instr, mem_word(32'hC));
    chk("stall_addr", imem_addr, 32'h10);
    cyc(0, 0, 0);
    chk("unstall_pc", instr_pc, 32'h10);

    // Redirect while a fetch waits: squash, then jump.
    lat_cfg = 3;
    cyc(0, 0, 0);
    cyc(0, 1, 32'h100);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("sq_addr", imem_addr, 32'h100);
    chk("sq_valid", 32'(instr_valid), 32'h0);
    lat_cfg = 0;
    cyc(0, 0, 0);
    chk("sq_pc", instr_pc, 32'h100);

    // Redirect coincident with an ack.
    cyc(0, 1, 32'h40);
    chk("ackred_addr", imem_addr, 32'h40);
    chk("ackred_valid", 32'(instr_valid), 32'h0);

    // Newest redirect wins during squash.
    lat_cfg = 3;
    cyc(0, 0, 0);
    cyc(0, 1, 32'h300);
    cyc(0, 1, 32'h200);
    cyc(0, 0, 0);
    chk("resq_addr", imem_addr, 32'h200);
    lat_cfg = 0;
    cyc(0, 0, 0);
    chk("resq_pc", instr_pc, 32'h200);

    // Low target bits ignored; PC wraps at the top of the address space.
    cyc(0, 1, 32'hFFFF_FFFF);
    chk("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", instr_pc_plus4, 32'h0);

    // Memory never acks.
    lat_cfg = 1000;
    repeat (12) cyc(0, 0, 0);
`ifdef FETCH_TIMEOUT_EN
    chk("to_fault", 32'(fetch_fault), 32'h1);
    chk("to_req", 32'(imem_req), 32'h0);
`else
    chk("to_fault", 32'(fetch_fault), 32'h0);
    chk("to_req", 32'(imem_req), 32'h1);
`endif
    // Reset in the middle of an outstanding request.
    do_reset();
    chk("mid_rst_addr", imem_addr, 32'h0);

    // Randomized traffic.
    lat_cfg = -1;
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 8, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
